reg_bank: RTL

Parametrised general-purpose register bank for the bus-based datapath. It replaces the single fixed-width load-enabled register with NUM_REGS registers of WIDTH bits. Registers are loaded from the shared bus and read through an asynchronous read port. The bank adds in-place unary operations and a multi-cycle register swap sequenced by an internal FSM with a busy/done handshake. It sits between the shared bus and the ALU operand muxes.

---
 rtl/reg_bank.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank
// Purpose  : General-purpose register bank of NUM_REGS x WIDTH registers.
//            Registers are loaded from the shared bus, read asynchronously,
//            modified in place by unary ops (CLR/INC/DEC/SHL), and exchanged
//            pairwise by a four-state swap sequencer with busy/done handshake.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous reset, active low
//            bus       - write data
//            wr_en     - load bus into R[wr_addr]
//            wr_addr   - write address
//            op_en     - apply op_code to R[op_addr]
//            op_code   - 00 CLR, 01 INC, 10 DEC, 11 SHL
//            op_addr   - operation address
//            swap_req  - start swap of R[swap_a] and R[swap_b]
//            swap_a/b  - swap operands
//            rd_addr   - read address
//            rd_data   - combinational R[rd_addr], 0 when out of range
//            busy      - swap sequencer not idle
//            swap_done - one-cycle pulse when a swap completes
//            ovf       - registered, one cycle after INC/DEC/SHL overflow
// Options  : REG_BANK_SAT_EN - INC/DEC saturate instead of wrapping
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank #(
  parameter  int WIDTH    = 3,
  parameter  int NUM_REGS = 4,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] bus,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             op_en,
  input  logic [1:0]       op_code,
  input  logic [AW-1:0]    op_addr,
  input  logic             swap_req,
  input  logic [AW-1:0]    swap_a,
  input  logic [AW-1:0]    swap_b,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             swap_done,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_T = 2'd1,
    S_MOVE_A = 2'd2,
    S_MOVE_B = 2'd3
  } state_e;

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] tmp_q, tmp_d;
  logic [AW-1:0]    a_q, a_d, b_q, b_d;
  state_e           state_q, state_d;
  logic             swap_done_q, swap_done_d;
  logic             ovf_q, ovf_d;

  // Operand selection and op result; out-of-range addresses never hit.
  logic [WIDTH-1:0] op_val, op_res, rb_val;
  logic             op_hit, op_ovf, sa_hit, sb_hit, op_apply;

  always_comb begin
    rd_data = '0;
    op_val  = '0;
    op_hit  = 1'b0;
    sa_hit  = 1'b0;
    sb_hit  = 1'b0;
    rb_val  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == AW'(i)) rd_data = regs_q[i];
      if (op_addr == AW'(i)) begin
        op_val = regs_q[i];
        op_hit = 1'b1;
      end
      if (swap_a == AW'(i)) sa_hit = 1'b1;
      if (swap_b == AW'(i)) sb_hit = 1'b1;
      if (b_q == AW'(i)) rb_val = regs_q[i];
    end
  end

  always_comb begin
    op_res = op_val;
    op_ovf = 1'b0;
    case (op_code)
      2'b00: op_res = '0;
      2'b01: begin
        op_ovf = &op_val;
`ifdef REG_BANK_SAT_EN
        op_res = op_ovf ? op_val : op_val + WIDTH'(1);
`else
        op_res = op_val + WIDTH'(1);
`endif
      end
      2'b10: begin
        op_ovf = (op_val == '0);
`ifdef REG_BANK_SAT_EN
        op_res = op_ovf ? op_val : op_val - WIDTH'(1);
`else
        op_res = op_val - WIDTH'(1);
`endif
      end
      default: begin
        op_ovf = op_val[WIDTH-1];
        op_res = {op_val[WIDTH-2:0], 1'b0};
      end
    endcase
  end

  // A same-address write takes priority and suppresses the op entirely,
  // including its overflow flag.
  assign op_apply = (state_q == S_IDLE) && op_en && op_hit &&
                    !(wr_en && (wr_addr == op_addr));

  always_comb begin
    regs_d      = regs_q;
    tmp_d       = tmp_q;
    a_d         = a_q;
    b_d         = b_q;
    state_d     = state_q;
    swap_done_d = 1'b0;
    ovf_d       = op_apply && op_ovf;
    case (state_q)
      S_IDLE: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (op_apply && (op_addr == AW'(i))) regs_d[i] = op_res;
          if (wr_en && (wr_addr == AW'(i)))    regs_d[i] = bus;
        end
        // Swaps naming a nonexistent register are dropped outright.
        if (swap_req && sa_hit && sb_hit) begin
          a_d     = swap_a;
          b_d     = swap_b;
          state_d = S_LOAD_T;
        end
      end
      S_LOAD_T: begin
        for (int i = 0; i < NUM_REGS; i++)
          if (a_q == AW'(i)) tmp_d = regs_q[i];
        state_d = S_MOVE_A;
      end
      S_MOVE_A: begin
        for (int i = 0; i < NUM_REGS; i++)
          if (a_q == AW'(i)) regs_d[i] = rb_val;
        state_d = S_MOVE_B;
      end
      default: begin
        for (int i = 0; i < NUM_REGS; i++)
          if (b_q == AW'(i)) regs_d[i] = tmp_q;
        swap_done_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      tmp_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      state_q     <= S_IDLE;
      swap_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      tmp_q       <= tmp_d;
      a_q         <= a_d;
      b_q         <= b_d;
      state_q     <= state_d;
      swap_done_q <= swap_done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign swap_done = swap_done_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire
